pc_target_unit: RTL
===================

// Module: pc_target_unit
// PURPOSE
//  Owns the fetch PC and closes the loop from the ALU back to the PC.
//  Streams the fetch address to the core and tracks each fetched PC for two stages, so the PC of
//  the instruction in execute is known. Accepts the jump/branch target computed by the ALU
//  (operand 1 = that execute-stage PC), redirects fetch and squashes the two wrong-path slots.
//  Supplies the link value (PC+step) for JAL/JALR write-back.
// PARAMETERS
//  PC_RESET  32'h0000_0000  fetch address loaded on reset
//  PC_STEP   4              fetch increment in bytes
//  (data width is `REG_LEN from rysy_pkg.vh; pipeline depth fetch->execute is fixed at 2)
// PORTS
//  clk       in   1         core clock, all state on posedge
//  rst       in   1         synchronous, active-high reset
//  stall     in   1         hold: freezes pc, history, valid bits and flush counter
//  jump_req  in   1         execute-stage instr is JAL/JALR/taken branch; alu_out holds target
//  alu_out   in   REG_LEN   target address from ALU
//  pc        out  REG_LEN   current fetch address (registered)
//  pc_ex     out  REG_LEN   PC of instruction in execute (fetch PC delayed 2 unstalled cycles)
//  ex_valid  out  1         execute slot holds a real (non-squashed) instruction
//  pc_link   out  REG_LEN   pc_ex + PC_STEP, combinational, for rd write-back
//  flush     out  1         squash fetch/decode; high while state==FLUSH
//  misalign  out  1         one-cycle pulse: accepted target had alu_out[1]==1
// BEHAVIOUR
//  Reset (rst=1 at posedge, overrides all): pc=PC_RESET, hist1=hist0=PC_RESET, v1=v0=0,
//   state=RUN, cnt=0, misalign=0; so pc_ex=PC_RESET, ex_valid=0, flush=0.
//  States: RUN, FLUSH (2-bit cnt). flush = (state==FLUSH); ex_valid = v0; pc_ex = hist0.
//  stall=1: every register holds (misalign cleared); jump_req is not accepted.
//  Unstalled cycle, no accept: pc<=pc+PC_STEP (mod 2^REG_LEN, 32'hFFFF_FFFC -> 0 silently);
//   hist1<=pc; hist0<=hist1; v1<=1; v0<=v1.
//  Accept = !stall & jump_req & ex_valid & state==RUN. On accept edge:
//   pc<={alu_out[REG_LEN-1:2],2'b00} (bits[1:0] forced 0); misalign<=alu_out[1];
//   v1<=0; v0<=0 (kills both wrong-path slots); hist1<=pc; hist0<=hist1;
//   state<=FLUSH; cnt<=1.
//  FLUSH, unstalled edge: pc keeps incrementing from target; v1<=1; v0<=v1;
//   cnt==1 -> cnt<=0; cnt==0 -> state<=RUN. flush high exactly 2 unstalled cycles.
//  Target instr reaches execute with ex_valid=1 on the cycle state returns to RUN.
//  jump_req ignored in FLUSH or when ex_valid=0 (squashed slots never redirect).
//  Simultaneous rst with jump_req/stall: rst wins. rst mid-FLUSH -> RUN, pc=PC_RESET.
//  Latency: accept edge -> new pc visible next cycle (1 cycle); target in execute 2 cycles later.
//  misalign is a 1-cycle registered pulse; no other side effect.
// TESTING
//  1 Reset: rst 1 cycle -> pc=0, ex_valid=0, flush=0; 3 free cycles -> pc=0xC, pc_ex=0x4,
//    ex_valid=1, pc_link=0x8.
//  2 Jump: pc_ex=0x10 valid, jump_req=1, alu_out=0x100 -> pc=0x100 next, flush=1 for 2 cycles,
//    ex_valid=0 for 2 cycles, then pc_ex=0x100, ex_valid=1, pc_link=0x104.
//  3 Ignored: jump_req held high through FLUSH -> no second redirect; pc=0x104,0x108 sequence.
//  4 Stall: stall=1 for 3 cycles inside FLUSH (cnt=1) -> pc, cnt, flush frozen; flush total
//    unstalled cycles still 2; jump_req with stall=1 in RUN -> not accepted.
//  5 Misalign/alignment: alu_out=0x203 accepted -> pc=0x200, misalign pulse 1 cycle;
//    alu_out=0x201 -> pc=0x200, misalign=0.
//  6 Wrap/reset: PC_RESET=32'hFFFF_FFF8 -> pc FFFF_FFFC, 0, 4; rst asserted during FLUSH ->
//    next cycle state RUN, flush=0, pc=PC_RESET, ex_valid=0.

Source files
------------

// File: rtl/pc_target_unit.sv
// Fetch PC owner: streams the fetch address, tracks fetched PCs two stages deep to execute,
// redirects fetch to the ALU-computed target and squashes the two wrong-path slots.
module pc_target_unit #(
  parameter int unsigned        REG_LEN  = 32,
  parameter logic [REG_LEN-1:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned        PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               jump_req,
  input  logic [REG_LEN-1:0] alu_out,
  output logic [REG_LEN-1:0] pc,
  output logic [REG_LEN-1:0] pc_ex,
  output logic               ex_valid,
  output logic [REG_LEN-1:0] pc_link,
  output logic               flush,
  output logic               misalign
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic [REG_LEN-1:0] STEP = REG_LEN'(PC_STEP);

  state_e             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [REG_LEN-1:0] pc_q, pc_d;
  logic [REG_LEN-1:0] hist1_q, hist1_d;
  logic [REG_LEN-1:0] hist0_q, hist0_d;
  logic               v1_q, v1_d;
  logic               v0_q, v0_d;
  logic               misalign_q, misalign_d;
  logic               accept_s;
  logic               unused_s;

  // Bit 0 of the target never matters: bit 1 flags misalignment, both are cleared in pc.
  assign unused_s = alu_out[0];

  // State register: every flop of the unit, reset synchronously.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= 2'd0;
      pc_q       <= PC_RESET;
      hist1_q    <= PC_RESET;
      hist0_q    <= PC_RESET;
      v1_q       <= 1'b0;
      v0_q       <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      hist1_q    <= hist1_d;
      hist0_q    <= hist0_d;
      v1_q       <= v1_d;
      v0_q       <= v0_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state logic: fetch advance, history shift, redirect and flush countdown.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    hist1_d    = hist1_q;
    hist0_d    = hist0_q;
    v1_d       = v1_q;
    v0_d       = v0_q;
    misalign_d = 1'b0;
    accept_s   = !stall && jump_req && v0_q && (state_q == ST_RUN);
    if (stall) begin
      state_d = state_q;
    end else begin
      hist1_d = pc_q;
      hist0_d = hist1_q;
      v1_d    = 1'b1;
      v0_d    = v1_q;
      if (accept_s) begin
        pc_d       = {alu_out[REG_LEN-1:2], 2'b00};
        misalign_d = alu_out[1];
        v1_d       = 1'b0;
        v0_d       = 1'b0;
        state_d    = ST_FLUSH;
        cnt_d      = 2'd1;
      end else begin
        pc_d = pc_q + STEP;
        case (state_q)
          ST_RUN: begin
            state_d = ST_RUN;
          end
          ST_FLUSH: begin
            // Two unstalled flush cycles: cnt 1 -> 0, then back to RUN.
            if (cnt_q == 2'd1) begin
              cnt_d = 2'd0;
            end else begin
              state_d = ST_RUN;
            end
          end
          default: begin
            state_d = ST_RUN;
          end
        endcase
      end
    end
  end

  // Output logic: registered state exposed, link value derived from the execute PC.
  always_comb begin
    pc       = pc_q;
    pc_ex    = hist0_q;
    ex_valid = v0_q;
    flush    = (state_q == ST_FLUSH);
    misalign = misalign_q;
    pc_link  = hist0_q + STEP;
  end

endmodule
